dispatch_ctrl: RTL and testbench

DISPATCH_CTRL -- requirements
Module: dispatch_ctrl

---
 rtl/dispatch_ctrl.sv | 140 ++++++++++++++
 tb/tb_dispatch_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dispatch_ctrl.sv
// Dispatch controller: gates instructions from fetch into the issue queues and
// tracks unresolved branches. Taken resolutions redirect fetch and flush.
module dispatch_ctrl #(
    parameter int NUM_Q     = 4,
    parameter int MAX_BR    = 2,
    parameter int FLUSH_CYC = 1,
    parameter int ADDR_W    = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_fetch_empty_flag,
    input  logic [NUM_Q-1:0]  i_dec_qsel,
    input  logic              i_dec_rd_en,
    input  logic              i_dec_branch,
    input  logic              i_dec_jmp,
    input  logic [ADDR_W-1:0] i_jmp_addr,
    input  logic [NUM_Q-1:0]  i_q_full,
    input  logic              i_tag_empty,
    input  logic              cdb_branch,
    input  logic              cdb_branch_taken,
    input  logic [ADDR_W-1:0] cdb_br_addr,
    output logic [NUM_Q-1:0]  o_dispatch_en,
    output logic              o_tag_rd_en,
    output logic              dispatch_rd_en,
    output logic              dispatch_jmp_valid,
    output logic [ADDR_W-1:0] dispatch_jmp_br_addr,
    output logic              o_flush,
    output logic [2:0]        o_br_cnt,
    output logic [1:0]        o_state,
    output logic              o_err
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        BR_FULL = 2'd1,
        FLUSH   = 2'd2
    } state_t;

    localparam logic [2:0] MAX_CNT  = 3'(MAX_BR);
    localparam logic [3:0] FLUSH_LD = 4'(FLUSH_CYC);

    state_t     state;
    state_t     state_next;
    logic [2:0] br_cnt;
    logic [2:0] br_cnt_next;
    logic [3:0] flush_cnt;
    logic [3:0] flush_cnt_next;
    logic       err;
    logic       err_next;

    logic taken;
    logic not_taken;
    logic q_ok;
    logic tag_ok;
    logic br_ok;
    logic go;
    logic br_go;

    // Everything combinational is qualified by i_rst_n so outputs read zero during reset.
    always_comb begin
        taken     = cdb_branch & cdb_branch_taken;
        not_taken = cdb_branch & ~cdb_branch_taken;
        q_ok      = ~|(i_dec_qsel & i_q_full);
        tag_ok    = ~i_dec_rd_en | ~i_tag_empty;
        br_ok     = ~i_dec_branch | (state == RUN) | cdb_branch;
        go        = i_rst_n & ~i_fetch_empty_flag & (state != FLUSH) &
                    q_ok & tag_ok & br_ok & ~taken;
        br_go     = go & i_dec_branch;
    end

    always_comb begin
        o_dispatch_en        = '0;
        o_tag_rd_en          = 1'b0;
        dispatch_rd_en       = 1'b0;
        dispatch_jmp_valid   = 1'b0;
        dispatch_jmp_br_addr = '0;
        o_flush              = 1'b0;
        if (go) begin
            o_dispatch_en  = i_dec_qsel;
            o_tag_rd_en    = i_dec_rd_en;
            dispatch_rd_en = 1'b1;
        end
        if (i_rst_n && taken) begin
            dispatch_jmp_valid   = 1'b1;
            dispatch_jmp_br_addr = cdb_br_addr;
            o_flush              = 1'b1;
        end else if (go && i_dec_jmp) begin
            dispatch_jmp_valid   = 1'b1;
            dispatch_jmp_br_addr = i_jmp_addr;
        end
    end

    always_comb begin
        state_next     = state;
        br_cnt_next    = br_cnt;
        flush_cnt_next = flush_cnt;
        err_next       = err;
        if (not_taken && br_cnt == 3'd0) begin
            err_next = 1'b1;
        end
        if (taken) begin
            br_cnt_next    = 3'd0;
            flush_cnt_next = FLUSH_LD;
            state_next     = FLUSH;
        end else begin
            if (br_go && !not_taken) begin
                br_cnt_next = br_cnt + 3'd1;
            end else if (not_taken && !br_go && br_cnt != 3'd0) begin
                br_cnt_next = br_cnt - 3'd1;
            end
            // The edge that drains the flush counter is the one that reopens dispatch.
            if (state == FLUSH && flush_cnt > 4'd1) begin
                flush_cnt_next = flush_cnt - 4'd1;
                state_next     = FLUSH;
            end else begin
                flush_cnt_next = 4'd0;
                state_next     = (br_cnt_next == MAX_CNT) ? BR_FULL : RUN;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= RUN;
            br_cnt    <= 3'd0;
            flush_cnt <= 4'd0;
            err       <= 1'b0;
        end else begin
            state     <= state_next;
            br_cnt    <= br_cnt_next;
            flush_cnt <= flush_cnt_next;
            err       <= err_next;
        end
    end

    assign o_br_cnt = br_cnt;
    assign o_state  = state;
    assign o_err    = err;

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Bench for dispatch_ctrl: two instances (FLUSH_CYC 1 and 3) share stimulus and
// are checked every cycle against a counter-level model plus literal spot checks.
module tb_dispatch_ctrl;

    localparam int MAX_BR = 2;
    localparam int FC0    = 1;
    localparam int FC1    = 3;

    logic        clk;
    logic        rst_n;
    logic        fe;
    logic [3:0]  qsel;
    logic        rd;
    logic        br;
    logic        jmp;
    logic [31:0] ja;
    logic [3:0]  qf;
    logic        te;
    logic        cb;
    logic        ct;
    logic [31:0] ca;

    logic [1:0][3:0]  den;
    logic [1:0]       trd;
    logic [1:0]       frd;
    logic [1:0]       jv;
    logic [1:0][31:0] jaddr;
    logic [1:0]       fl;
    logic [1:0][2:0]  cnt;
    logic [1:0][1:0]  st;
    logic [1:0]       er;

    int m_cnt [2];
    int m_fl  [2];
    bit m_err [2];

    int errors = 0;
    int checks = 0;

    dispatch_ctrl #(.NUM_Q(4), .MAX_BR(MAX_BR), .FLUSH_CYC(FC0), .ADDR_W(32)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_fetch_empty_flag(fe), .i_dec_qsel(qsel),
        .i_dec_rd_en(rd), .i_dec_branch(br), .i_dec_jmp(jmp), .i_jmp_addr(ja),
        .i_q_full(qf), .i_tag_empty(te), .cdb_branch(cb), .cdb_branch_taken(ct),
        .cdb_br_addr(ca), .o_dispatch_en(den[0]), .o_tag_rd_en(trd[0]),
        .dispatch_rd_en(frd[0]), .dispatch_jmp_valid(jv[0]),
        .dispatch_jmp_br_addr(jaddr[0]), .o_flush(fl[0]), .o_br_cnt(cnt[0]),
        .o_state(st[0]), .o_err(er[0])
    );

    dispatch_ctrl #(.NUM_Q(4), .MAX_BR(MAX_BR), .FLUSH_CYC(FC1), .ADDR_W(32)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_fetch_empty_flag(fe), .i_dec_qsel(qsel),
        .i_dec_rd_en(rd), .i_dec_branch(br), .i_dec_jmp(jmp), .i_jmp_addr(ja),
        .i_q_full(qf), .i_tag_empty(te), .cdb_branch(cb), .cdb_branch_taken(ct),
        .cdb_br_addr(ca), .o_dispatch_en(den[1]), .o_tag_rd_en(trd[1]),
        .dispatch_rd_en(frd[1]), .dispatch_jmp_valid(jv[1]),
        .dispatch_jmp_br_addr(jaddr[1]), .o_flush(fl[1]), .o_br_cnt(cnt[1]),
        .o_state(st[1]), .o_err(er[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int flush_len(int k);
        return (k == 0) ? FC0 : FC1;
    endfunction

    // An instruction is accepted when nothing in the rules holds it back.
    function automatic bit model_go(int k);
        return !fe && m_fl[k] == 0 && (qsel & qf) == 4'b0 && !(rd && te) &&
               (!br || m_cnt[k] < MAX_BR || cb) && !(cb && ct);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_cnt[k] <= 0;
                m_fl[k]  <= 0;
                m_err[k] <= 1'b0;
            end else begin
                if (cb && !ct && m_cnt[k] == 0)
                    m_err[k] <= 1'b1;
                if (cb && ct) begin
                    m_cnt[k] <= 0;
                    m_fl[k]  <= flush_len(k);
                end else begin
                    if (m_fl[k] > 0)
                        m_fl[k] <= m_fl[k] - 1;
                    if (model_go(k) && br && !cb)
                        m_cnt[k] <= m_cnt[k] + 1;
                    else if (cb && !(model_go(k) && br) && m_cnt[k] > 0)
                        m_cnt[k] <= m_cnt[k] - 1;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input int k,
                               input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s dut%0d actual=%0h expected=%0h at %0t",
                     name, k, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                checkOutput("rst_den",   k, 32'(den[k]),   32'd0);
                checkOutput("rst_trd",   k, 32'(trd[k]),   32'd0);
                checkOutput("rst_rd",    k, 32'(frd[k]),   32'd0);
                checkOutput("rst_jv",    k, 32'(jv[k]),    32'd0);
                checkOutput("rst_jaddr", k, jaddr[k],      32'd0);
                checkOutput("rst_flush", k, 32'(fl[k]),    32'd0);
                checkOutput("rst_cnt",   k, 32'(cnt[k]),   32'd0);
                checkOutput("rst_state", k, 32'(st[k]),    32'd0);
                checkOutput("rst_err",   k, 32'(er[k]),    32'd0);
            end else begin
                checkOutput("den",   k, 32'(den[k]), model_go(k) ? 32'(qsel) : 32'd0);
                checkOutput("trd",   k, 32'(trd[k]), 32'(model_go(k) && rd));
                checkOutput("rd",    k, 32'(frd[k]), 32'(model_go(k)));
                checkOutput("jv",    k, 32'(jv[k]),  32'((cb && ct) || (model_go(k) && jmp)));
                checkOutput("jaddr", k, jaddr[k],
                            (cb && ct) ? ca : ((model_go(k) && jmp) ? ja : 32'd0));
                checkOutput("flush", k, 32'(fl[k]),  32'(cb && ct));
                checkOutput("cnt",   k, 32'(cnt[k]), 32'(m_cnt[k]));
                checkOutput("state", k, 32'(st[k]),
                            (m_fl[k] > 0) ? 32'd2 : ((m_cnt[k] == MAX_BR) ? 32'd1 : 32'd0));
                checkOutput("err",   k, 32'(er[k]),  32'(m_err[k]));
            end
        end
    end

    // Drives one cycle's inputs just after the edge and returns at the sampling edge.
    task automatic applyStimulus(input logic f_e, input logic [3:0] q_s, input logic r_d,
                                 input logic b_r, input logic j_m, input logic [31:0] j_a,
                                 input logic [3:0] q_f, input logic t_e, input logic c_b,
                                 input logic c_t, input logic [31:0] c_a);
        fe = f_e; qsel = q_s; rd = r_d; br = b_r; jmp = j_m; ja = j_a;
        qf = q_f; te = t_e; cb = c_b; ct = c_t; ca = c_a;
        @(negedge clk);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(1, 4'b0000, 0, 0, 0, 32'h0, 4'b0000, 0, 0, 0, 32'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        $display("[TB] reset with live inputs");
        applyStimulus(0, 4'b0001, 1, 0, 1, 32'h100, 4'b0000, 0, 1, 1, 32'h40);
        checkOutput("lit_rst_rd", 0, 32'(frd[0]), 32'd0);
        checkOutput("lit_rst_jv", 1, 32'(jv[1]),  32'd0);
        nextCycle();
        rst_n = 1'b1;

        $display("[TB] three back-to-back branches");
        applyStimulus(0, 4'b0001, 0, 1, 0, 32'h0, 4'b0000, 0, 0, 0, 32'h0);
        checkOutput("lit_br1_rd", 0, 32'(frd[0]), 32'd1);
        nextCycle();
        applyStimulus(0, 4'b0001, 0, 1, 0, 32'h0, 4'b0000, 0, 0, 0, 32'h0);
        checkOutput("lit_br2_cnt", 0, 32'(cnt[0]), 32'd1);
        nextCycle();
        applyStimulus(0, 4'b0001, 0, 1, 0, 32'h0, 4'b0000, 0, 0, 0, 32'h0);
        checkOutput("lit_br3_cnt",   0, 32'(cnt[0]), 32'd2);
        checkOutput("lit_br3_state", 0, 32'(st[0]),  32'd1);
        checkOutput("lit_br3_rd",    0, 32'(frd[0]), 32'd0);
        checkOutput("lit_br3_den",   0, 32'(den[0]), 32'd0);
        nextCycle();

        $display("[TB] not-taken resolution frees the stalled branch");
        applyStimulus(0, 4'b0001, 0, 1, 0, 32'h0, 4'b0000, 0, 1, 0, 32'h0);
        checkOutput("lit_nt_rd", 1, 32'(frd[1]), 32'd1);
        nextCycle();
        applyStimulus(0, 4'b0010, 1, 0, 0, 32'h0, 4'b0000, 0, 0, 0, 32'h0);
        checkOutput("lit_nt_cnt",  0, 32'(cnt[0]), 32'd2);
        checkOutput("lit_full_trd", 0, 32'(trd[0]), 32'd1);
        checkOutput("lit_full_den", 0, 32'(den[0]), 32'h2);
        nextCycle();

        $display("[TB] taken resolution against a presented jump");
        applyStimulus(0, 4'b0001, 0, 0, 1, 32'h100, 4'b0000, 0, 1, 1, 32'h40);
        checkOutput("lit_tk_addr",  0, jaddr[0],       32'h40);
        checkOutput("lit_tk_flush", 0, 32'(fl[0]),     32'd1);
        checkOutput("lit_tk_jv",    0, 32'(jv[0]),     32'd1);
        checkOutput("lit_tk_rd",    0, 32'(frd[0]),    32'd0);
        nextCycle();
        applyStimulus(0, 4'b0001, 0, 0, 0, 32'h0, 4'b0000, 0, 0, 0, 32'h0);
        checkOutput("lit_fl1_rd",    0, 32'(frd[0]), 32'd0);
        checkOutput("lit_fl1_state", 1, 32'(st[1]),  32'd2);
        nextCycle();
        applyStimulus(0, 4'b0001, 0, 0, 0, 32'h0, 4'b0000, 0, 0, 0, 32'h0);
        checkOutput("lit_fl2_rd0", 0, 32'(frd[0]), 32'd1);
        checkOutput("lit_fl2_cnt", 0, 32'(cnt[0]), 32'd0);
        checkOutput("lit_fl2_rd1", 1, 32'(frd[1]), 32'd0);
        nextCycle();
        applyStimulus(0, 4'b0001, 0, 0, 0, 32'h0, 4'b0000, 0, 0, 0, 32'h0);
        checkOutput("lit_fl3_rd1", 1, 32'(frd[1]), 32'd0);
        nextCycle();
        applyStimulus(0, 4'b0001, 0, 0, 0, 32'h0, 4'b0000, 0, 0, 0, 32'h0);
        checkOutput("lit_fl4_rd1",   1, 32'(frd[1]), 32'd1);
        checkOutput("lit_fl4_state", 1, 32'(st[1]),  32'd0);
        checkOutput("lit_fl4_cnt",   1, 32'(cnt[1]), 32'd0);
        nextCycle();
        applyStimulus(0, 4'b0001, 0, 0, 1, 32'h100, 4'b0000, 0, 0, 0, 32'h0);
        checkOutput("lit_jmp_addr", 0, jaddr[0],   32'h100);
        checkOutput("lit_jmp_jv",   1, 32'(jv[1]), 32'd1);
        nextCycle();

        $display("[TB] full queue and empty tag FIFO blockers");
        applyStimulus(0, 4'b0100, 0, 0, 0, 32'h0, 4'b0100, 0, 0, 0, 32'h0);
        checkOutput("lit_qf_den", 0, 32'(den[0]), 32'd0);
        checkOutput("lit_qf_rd",  0, 32'(frd[0]), 32'd0);
        nextCycle();
        applyStimulus(0, 4'b0100, 0, 0, 0, 32'h0, 4'b0000, 0, 0, 0, 32'h0);
        checkOutput("lit_qok_den", 0, 32'(den[0]), 32'h4);
        nextCycle();
        applyStimulus(0, 4'b0001, 1, 0, 0, 32'h0, 4'b0000, 1, 0, 0, 32'h0);
        checkOutput("lit_te_trd", 0, 32'(trd[0]), 32'd0);
        checkOutput("lit_te_rd",  0, 32'(frd[0]), 32'd0);
        nextCycle();
        applyStimulus(0, 4'b0001, 1, 0, 0, 32'h0, 4'b0000, 0, 0, 0, 32'h0);
        checkOutput("lit_tok_trd", 0, 32'(trd[0]), 32'd1);
        nextCycle();

        $display("[TB] not-taken resolution with no branch outstanding");
        applyStimulus(1, 4'b0000, 0, 0, 0, 32'h0, 4'b0000, 0, 1, 0, 32'h0);
        nextCycle();
        idleCycle();
        checkOutput("lit_err_set", 0, 32'(er[0]),  32'd1);
        checkOutput("lit_err_cnt", 0, 32'(cnt[0]), 32'd0);
        nextCycle();
        idleCycle();
        checkOutput("lit_err_sticky", 1, 32'(er[1]), 32'd1);
        nextCycle();

        $display("[TB] reset in the middle of a flush");
        rst_n = 1'b0;
        idleCycle();
        checkOutput("lit_err_clr", 0, 32'(er[0]), 32'd0);
        nextCycle();
        rst_n = 1'b1;
        applyStimulus(1, 4'b0000, 0, 0, 0, 32'h0, 4'b0000, 0, 1, 1, 32'h80);
        nextCycle();
        idleCycle();
        checkOutput("lit_mf_state", 1, 32'(st[1]), 32'd2);
        nextCycle();
        rst_n = 1'b0;
        applyStimulus(0, 4'b0001, 1, 0, 1, 32'h100, 4'b0000, 0, 1, 1, 32'h40);
        checkOutput("lit_mr_state", 1, 32'(st[1]),  32'd0);
        checkOutput("lit_mr_jv",    1, 32'(jv[1]),  32'd0);
        checkOutput("lit_mr_addr",  1, jaddr[1],    32'd0);
        checkOutput("lit_mr_rd",    1, 32'(frd[1]), 32'd0);
        nextCycle();
        rst_n = 1'b1;
        applyStimulus(0, 4'b0001, 0, 0, 0, 32'h0, 4'b0000, 0, 0, 0, 32'h0);
        checkOutput("lit_rel_rd",  1, 32'(frd[1]), 32'd1);
        checkOutput("lit_rel_den", 1, 32'(den[1]), 32'h1);
        nextCycle();
        idleCycle();
        nextCycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
